// File: rtl/dff_link_var_delay.sv
// Programmable-delay register chain with per-stage valid, runtime tap select,
// flush and occupancy count. Define DFF_LINK_OUT_REG_EN to register the tap outputs.
module dff_link_var_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             shift_en,
  input  logic             flush,
  input  logic             input_valid,
  input  logic [WIDTH-1:0] input_data,
  input  logic [SEL_W-1:0] delay_sel,
  output logic             output_valid,
  output logic [WIDTH-1:0] output_data,
  output logic [SEL_W:0]   fill_count,
  output logic             full
);

  localparam logic [SEL_W:0]   DEPTH_CNT = (SEL_W+1)'(DEPTH);
  localparam logic [SEL_W-1:0] LAST_TAP  = SEL_W'(DEPTH-1);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [SEL_W:0]   cnt;
  logic [SEL_W:0]   cnt_next;
  logic [SEL_W-1:0] tap;
  logic [WIDTH-1:0] tap_data;
  logic             tap_vld;

  // Entering and leaving valid bits cancel, so cnt stays within 0..DEPTH.
  always_comb begin
    cnt_next = cnt + (SEL_W+1)'(input_valid) - (SEL_W+1)'(vld[DEPTH-1]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
      vld <= '0;
      cnt <= '0;
    end else if (flush) begin
      vld <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      data[0] <= input_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
      end
      vld <= {vld[DEPTH-2:0], input_valid};
      cnt <= cnt_next;
    end
  end

  always_comb begin
    tap = ({1'b0, delay_sel} >= DEPTH_CNT) ? LAST_TAP : delay_sel;
    tap_data = data[tap];
    tap_vld  = vld[tap];
  end

`ifdef DFF_LINK_OUT_REG_EN
  logic             out_vld_q;
  logic [WIDTH-1:0] out_data_q;

  // Flush clears only the valid flag; the data register keeps its last value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (flush) begin
      out_vld_q  <= 1'b0;
    end else begin
      out_vld_q  <= tap_vld;
      out_data_q <= tap_data;
    end
  end

  always_comb begin
    output_valid = out_vld_q;
    output_data  = out_data_q;
  end
`else
  always_comb begin
    output_valid = tap_vld;
    output_data  = tap_data;
  end
`endif

  always_comb begin
    fill_count = cnt;
    full       = (cnt == DEPTH_CNT);
  end

endmodule

// File: tb/tb_dff_link_var_delay.sv
// Directed self-checking bench for dff_link_var_delay (combinational-tap build),
// with a second DEPTH=12 instance sharing the stimulus to exercise tap clamping.
module tb_dff_link_var_delay;

  logic       CLK = 1'b0;
  logic       RST;
  logic       shift_en;
  logic       flush;
  logic       input_valid;
  logic [7:0] input_data;
  logic [3:0] delay_sel;

  logic       output_valid;
  logic [7:0] output_data;
  logic [4:0] fill_count;
  logic       full;

  logic       o12_valid;
  logic [7:0] o12_data;
  logic [4:0] o12_fill;
  logic       o12_full;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dff_link_var_delay #(.WIDTH(8), .DEPTH(16), .SEL_W(4)) dut (
    .CLK(CLK), .RST(RST), .shift_en(shift_en), .flush(flush),
    .input_valid(input_valid), .input_data(input_data), .delay_sel(delay_sel),
    .output_valid(output_valid), .output_data(output_data),
    .fill_count(fill_count), .full(full)
  );

  dff_link_var_delay #(.WIDTH(8), .DEPTH(12), .SEL_W(4)) dut12 (
    .CLK(CLK), .RST(RST), .shift_en(shift_en), .flush(flush),
    .input_valid(input_valid), .input_data(input_data), .delay_sel(delay_sel),
    .output_valid(o12_valid), .output_data(o12_data),
    .fill_count(o12_fill), .full(o12_full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST         = 1'b1;
    flush       = 1'b0;
    shift_en    = 1'b1;
    input_valid = 1'($urandom_range(1, 0));
    input_data  = 8'($urandom);
    delay_sel   = 4'd3;

    // Reset over two edges with shifting requested
    tick();
    input_valid = 1'($urandom_range(1, 0));
    input_data  = 8'($urandom);
    tick();
    check("rst_data", output_data, 0);
    check("rst_valid", output_valid, 0);
    check("rst_fill", fill_count, 0);
    check("rst_full", full, 0);
    check("rst12_fill", o12_fill, 0);

    // Fixed delay of 3: sample i appears after the 4th shift
    RST = 1'b0;
    input_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      input_data = 8'(i);
      tick();
      check("fix_data", output_data, (i >= 4) ? i - 3 : 0);
      check("fix_valid", output_valid, (i >= 4) ? 1 : 0);
      check("fix_fill", fill_count, (i < 16) ? i : 16);
      check("fix_full", full, (i >= 16) ? 1 : 0);
    end

    // Load 0xA5 and stall
    input_data = 8'hA5;
    tick();
    delay_sel = 4'd0;
    #1;
    check("load_data", output_data, 32'hA5);
    shift_en   = 1'b0;
    input_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data", output_data, 32'hA5);
      check("stall_valid", output_valid, 1);
      check("stall_fill", fill_count, 16);
      check("stall_full", full, 1);
    end

    // Clamp: stage k holds 21-k for k >= 1
    delay_sel = 4'd15;
    #1;
    check("tap15_data", output_data, 6);
    check("clamp12_data", o12_data, 10);
    check("clamp12_valid", o12_valid, 1);
    check("clamp12_fill", o12_fill, 12);
    check("clamp12_full", o12_full, 1);

    // Bubbles: valid only on even j
    shift_en  = 1'b1;
    delay_sel = 4'd5;
    for (int j = 0; j < 32; j++) begin
      input_data  = 8'(8'h40 + j);
      input_valid = ~j[0];
      tick();
      if (j >= 16) begin
        check("bub_data", output_data, 8'h40 + j - 5);
        check("bub_valid", output_valid, j[0] ? 1 : 0);
      end
    end
    check("bub_fill", fill_count, 8);
    check("bub_full", full, 0);
    check("bub12_fill", o12_fill, 6);

    // Flush without shift: data kept, valids cleared
    flush    = 1'b1;
    shift_en = 1'b0;
    tick();
    check("fl_fill", fill_count, 0);
    check("fl_valid", output_valid, 0);
    check("fl_data", output_data, 32'h5A);
    flush       = 1'b0;
    shift_en    = 1'b1;
    input_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      input_data = 8'(8'h80 + i);
      tick();
    end
    check("fill10", fill_count, 10);
    check("fill10_12", o12_fill, 10);

    // Flush with shift: new input dropped, data intact
    flush      = 1'b1;
    input_data = 8'hEE;
    delay_sel  = 4'd0;
    tick();
    check("fs_fill", fill_count, 0);
    check("fs_data0", output_data, 32'h89);
    check("fs_valid0", output_valid, 0);
    delay_sel = 4'd9;
    #1;
    check("fs_data9", output_data, 32'h80);
    check("fs_valid9", output_valid, 0);
    flush = 1'b0;

    // Reset mid-stream with flush asserted
    delay_sel = 4'd0;
    for (int i = 0; i < 7; i++) begin
      input_data = 8'(8'h10 + i);
      tick();
    end
    check("mid_fill", fill_count, 7);
    check("mid_data", output_data, 32'h16);
    RST   = 1'b1;
    flush = 1'b1;
    tick();
    check("mrst_fill", fill_count, 0);
    check("mrst_data0", output_data, 0);
    check("mrst_valid", output_valid, 0);
    check("mrst_full", full, 0);
    delay_sel = 4'd6;
    #1;
    check("mrst_data6", output_data, 0);
    check("mrst12_fill", o12_fill, 0);
    RST   = 1'b0;
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
